// File: rtl/fas_pkg.sv
// Shared definitions for the FAS filter path.
// Contents:
//   FAS_TAPS/FAS_DW/FAS_CW/FAS_ACCW - default tap count and widths
//   state_e                         - FIR MAC scheduler states
//   sext_prod()                     - sign-extend a DW+CW product to ACCW bits
package fas_pkg;

  localparam int unsigned FAS_TAPS = 32;
  localparam int unsigned FAS_DW   = 16;
  localparam int unsigned FAS_CW   = 20;
  localparam int unsigned FAS_ACCW = 44;
  localparam int unsigned FAS_PW   = FAS_DW + FAS_CW;

  typedef enum logic [1:0] {
    StIdle,
    StMac,
    StDone
  } state_e;

  function automatic logic [FAS_ACCW-1:0] sext_prod(input logic [FAS_PW-1:0] p);
    return {{(FAS_ACCW - FAS_PW){p[FAS_PW-1]}}, p};
  endfunction

endpackage

// File: rtl/fir_hist_ram.sv
// Sample history store: DEPTH x DW register array.
// Ports:
//   clk, rst        - clock, synchronous active-high reset (zeroes array)
//   clr             - synchronous clear of every slot
//   we/waddr/wdata  - write port; a write coincident with clr lands after the clear
//   raddr/rdata     - combinational read port
module fir_hist_ram #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned DW    = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end
    // Later assignment wins, so a write alongside clr survives the clear.
    if (!rst && we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/fir_mac_sched.sv
// Time-multiplexed FIR controller sharing one external signed multiplier.
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   data_valid, data_in       - input sample strobe and signed sample
//   ready                     - sample can be accepted (idle)
//   clear_hist                - zero history and write pointer (idle only)
//   coef_we/addr/data         - coefficient table write (idle only)
//   cfg_err                   - one-cycle pulse when a config strobe was dropped while busy
//   mul_a, mul_b, mul_en      - multiplier operands x[n-k], coef[k] and their valid
//   mul_p                     - signed product, combinational from mul_a/mul_b
//   out_valid, out_data       - one-cycle result strobe, result held until the next
module fir_mac_sched
  import fas_pkg::*;
#(
  parameter int unsigned TAPS = FAS_TAPS,
  parameter int unsigned DW   = FAS_DW,
  parameter int unsigned CW   = FAS_CW,
  parameter int unsigned ACCW = FAS_ACCW
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     data_valid,
  input  logic [DW-1:0]            data_in,
  output logic                     ready,
  input  logic                     clear_hist,
  input  logic                     coef_we,
  input  logic [$clog2(TAPS)-1:0]  coef_addr,
  input  logic [CW-1:0]            coef_data,
  output logic                     cfg_err,
  output logic [DW-1:0]            mul_a,
  output logic [CW-1:0]            mul_b,
  output logic                     mul_en,
  input  logic [DW+CW-1:0]         mul_p,
  output logic                     out_valid,
  output logic [ACCW-1:0]          out_data
);

  localparam int unsigned AW = $clog2(TAPS);

  state_e          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   k_q;
  logic [ACCW-1:0] acc_q;
  logic [CW-1:0]   coef_q [TAPS];

  logic            is_idle;
  logic [AW-1:0]   hist_waddr;
  logic [AW-1:0]   hist_raddr;
  logic [DW-1:0]   hist_rdata;

  assign is_idle    = (state_q == StIdle);
  // A clear coincident with a sample restarts the buffer, so the sample lands in slot 0.
  assign hist_waddr = clear_hist ? '0 : wr_ptr_q;
  // AW-bit subtraction wraps modulo TAPS (TAPS is a power of two).
  assign hist_raddr = wr_ptr_q - k_q;

  fir_hist_ram #(
    .DEPTH(TAPS),
    .DW   (DW),
    .AW   (AW)
  ) u_hist (
    .clk  (clk),
    .rst  (rst),
    .clr  (is_idle && clear_hist),
    .we   (is_idle && data_valid),
    .waddr(hist_waddr),
    .wdata(data_in),
    .raddr(hist_raddr),
    .rdata(hist_rdata)
  );

  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    mul_en  = 1'b0;
    mul_a   = '0;
    mul_b   = '0;
    unique case (state_q)
      StIdle: begin
        ready = 1'b1;
        if (data_valid) state_d = StMac;
      end
      StMac: begin
        mul_en = 1'b1;
        mul_a  = hist_rdata;
        mul_b  = coef_q[k_q];
        if (k_q == AW'(TAPS - 1)) state_d = StDone;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      wr_ptr_q  <= '0;
      k_q       <= '0;
      acc_q     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      cfg_err   <= 1'b0;
      for (int i = 0; i < TAPS; i++) begin
        coef_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      out_valid <= 1'b0;
      // Both strobes dropped together still give a single pulse.
      cfg_err   <= !is_idle && (coef_we || clear_hist);
      unique case (state_q)
        StIdle: begin
          if (coef_we)    coef_q[coef_addr] <= coef_data;
          if (clear_hist) wr_ptr_q <= '0;
          if (data_valid) begin
            acc_q <= '0;
            k_q   <= '0;
          end
        end
        StMac: begin
          acc_q <= acc_q + sext_prod(mul_p);
          k_q   <= k_q + AW'(1);
        end
        StDone: begin
          out_data  <= acc_q;
          out_valid <= 1'b1;
          wr_ptr_q  <= wr_ptr_q + AW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_sched.sv
// Self-checking bench for fir_mac_sched (TAPS=4) with an ideal signed multiplier.
module tb_fir_mac_sched;

  localparam int unsigned TAPS = 4;
  localparam int unsigned DW   = 16;
  localparam int unsigned CW   = 20;
  localparam int unsigned ACCW = 44;
  localparam int unsigned AW   = 2;
  localparam int unsigned PW   = DW + CW;

  logic            clk = 1'b0;
  logic            rst;
  logic            data_valid;
  logic [DW-1:0]   data_in;
  logic            ready;
  logic            clear_hist;
  logic            coef_we;
  logic [AW-1:0]   coef_addr;
  logic [CW-1:0]   coef_data;
  logic            cfg_err;
  logic [DW-1:0]   mul_a;
  logic [CW-1:0]   mul_b;
  logic            mul_en;
  logic [PW-1:0]   mul_p;
  logic            out_valid;
  logic [ACCW-1:0] out_data;

  always #5 clk = ~clk;

  fir_mac_sched #(
    .TAPS(TAPS),
    .DW  (DW),
    .CW  (CW),
    .ACCW(ACCW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .data_valid(data_valid),
    .data_in   (data_in),
    .ready     (ready),
    .clear_hist(clear_hist),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .cfg_err   (cfg_err),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_en    (mul_en),
    .mul_p     (mul_p),
    .out_valid (out_valid),
    .out_data  (out_data)
  );

  // Ideal signed multiplier.
  logic signed [PW-1:0] ext_a, ext_b;
  assign ext_a = PW'($signed(mul_a));
  assign ext_b = PW'($signed(mul_b));
  assign mul_p = ext_a * ext_b;

  // Reference model: coefficient list and history as a newest-first sample list.
  longint coef_m [TAPS];
  longint hist_m [$];
  int     n_cmp = 0;
  int     n_err = 0;

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint s16(input logic [DW-1:0] v);
    return longint'($signed(v));
  endfunction

  function automatic longint s20(input logic [CW-1:0] v);
    return longint'($signed(v));
  endfunction

  function automatic longint dut_out();
    return longint'($signed(out_data));
  endfunction

  task automatic model_clear_hist();
    hist_m = {};
    for (int i = 0; i < TAPS; i++) hist_m.push_back(0);
  endtask

  task automatic model_reset();
    for (int i = 0; i < TAPS; i++) coef_m[i] = 0;
    model_clear_hist();
  endtask

  function automatic longint model_filter();
    longint y = 0;
    for (int k = 0; k < TAPS; k++) y += coef_m[k] * hist_m[k];
    return y;
  endfunction

  // All task entries and exits happen on a falling edge.
  task automatic wait_ready();
    for (int i = 0; i < 20; i++) begin
      if (ready) return;
      @(negedge clk);
    end
    check_eq("ready_timeout", 0, 1);
  endtask

  task automatic write_coef(input logic [AW-1:0] a, input logic [CW-1:0] d);
    wait_ready();
    coef_we = 1'b1; coef_addr = a; coef_data = d;
    @(negedge clk);
    coef_we = 1'b0;
    coef_m[a] = s20(d);
  endtask

  task automatic pulse_clear();
    wait_ready();
    clear_hist = 1'b1;
    @(negedge clk);
    clear_hist = 1'b0;
    model_clear_hist();
  endtask

  // Feed one sample (with optional coincident config) and check timing and result.
  // poke: during MAC, drive data_valid, coef_we(0,99) and clear_hist for one cycle.
  task automatic feed(input logic [DW-1:0] x, input bit clr, input bit cwe,
                      input logic [AW-1:0] ca, input logic [CW-1:0] cd, input bit poke,
                      output longint y);
    longint exp;
    int     lat;
    int     rdy_low;
    bit     got;
    wait_ready();
    data_valid = 1'b1; data_in = x; clear_hist = clr;
    coef_we = cwe; coef_addr = ca; coef_data = cd;
    if (cwe) coef_m[ca] = s20(cd);
    if (clr) model_clear_hist();
    hist_m.push_front(s16(x));
    void'(hist_m.pop_back());
    exp = model_filter();
    got = 1'b0; lat = 0; rdy_low = 0; y = 0;
    @(posedge clk);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) begin
        data_valid = 1'b0; clear_hist = 1'b0; coef_we = 1'b0;
      end
      if (poke && i == 2) begin
        data_valid = 1'b1; data_in = DW'($urandom);
        coef_we = 1'b1; coef_addr = '0; coef_data = CW'(99); clear_hist = 1'b1;
      end
      if (poke && i == 3) begin
        check_eq("cfg_err_pulse", longint'(cfg_err), 1);
        data_valid = 1'b0; coef_we = 1'b0; clear_hist = 1'b0;
      end
      if (poke && i == 4) check_eq("cfg_err_single", longint'(cfg_err), 0);
      if (out_valid) begin
        got = 1'b1; lat = i; y = dut_out();
        break;
      end
      if (!ready) rdy_low++;
    end
    if (!got) begin
      check_eq("out_valid_timeout", 0, 1);
    end else begin
      check_eq("latency", lat, TAPS + 2);
      check_eq("ready_low_cycles", rdy_low, TAPS + 1);
      check_eq("out_data_model", y, exp);
      @(negedge clk);
      check_eq("out_valid_one_cycle", longint'(out_valid), 0);
      check_eq("out_data_held", dut_out(), exp);
    end
  endtask

  longint y;
  longint imp_exp [5]  = '{1, 2, 3, 4, 0};
  longint wrap_exp [9] = '{1, 3, 6, 10, 14, 18, 22, 26, 30};

  initial begin
    rst = 1'b1; data_valid = 1'b0; data_in = '0; clear_hist = 1'b0;
    coef_we = 1'b0; coef_addr = '0; coef_data = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_ready", longint'(ready), 1);
    check_eq("rst_out_valid", longint'(out_valid), 0);
    check_eq("rst_out_data", dut_out(), 0);
    check_eq("rst_cfg_err", longint'(cfg_err), 0);
    check_eq("rst_mul_en", longint'(mul_en), 0);

    // Impulse response.
    for (int i = 0; i < TAPS; i++) write_coef(AW'(i), CW'(i + 1));
    for (int i = 0; i < 5; i++) begin
      feed(DW'(i == 0 ? 1 : 0), 1'b0, 1'b0, '0, '0, 1'b0, y);
      check_eq("impulse", y, imp_exp[i]);
    end

    // Sign extremes.
    write_coef(0, 20'hFFFFF);
    for (int i = 1; i < TAPS; i++) write_coef(AW'(i), '0);
    feed(16'h8000, 1'b0, 1'b0, '0, '0, 1'b0, y);
    check_eq("neg_extreme", y, 32768);
    feed(16'h7FFF, 1'b0, 1'b0, '0, '0, 1'b0, y);
    check_eq("pos_extreme", y, -32767);

    // Wrap-around of the write pointer.
    for (int i = 0; i < TAPS; i++) write_coef(AW'(i), CW'(1));
    pulse_clear();
    for (int i = 0; i < 9; i++) begin
      feed(DW'(i + 1), 1'b0, 1'b0, '0, '0, 1'b0, y);
      check_eq("wrap", y, wrap_exp[i]);
    end

    // Busy protection.
    feed(DW'(3), 1'b0, 1'b0, '0, '0, 1'b1, y);
    feed(DW'(2), 1'b0, 1'b0, '0, '0, 1'b0, y);

    // Coincident sample, coefficient write and clear.
    feed(DW'(5), 1'b1, 1'b1, '0, CW'(7), 1'b0, y);
    check_eq("coincident", y, 35);
    feed(DW'(0), 1'b0, 1'b0, '0, '0, 1'b0, y);
    check_eq("coincident_hist", y, 5);

    // Reset in the middle of MAC.
    wait_ready();
    data_valid = 1'b1; data_in = DW'(1);
    @(posedge clk);
    begin
      int seen = 0;
      for (int i = 1; i <= 15; i++) begin
        @(negedge clk);
        if (i == 1) data_valid = 1'b0;
        if (i == 3) rst = 1'b1;
        if (i == 4) rst = 1'b0;
        if (i == 5) check_eq("rst_mid_ready", longint'(ready), 1);
        if (out_valid) seen++;
      end
      check_eq("rst_mid_no_valid", seen, 0);
      check_eq("rst_mid_out_data", dut_out(), 0);
    end
    model_reset();
    feed(DW'(1), 1'b0, 1'b0, '0, '0, 1'b0, y);
    check_eq("post_rst_zero_coef", y, 0);
    for (int i = 0; i < TAPS; i++) write_coef(AW'(i), CW'(i + 1));
    pulse_clear();
    feed(DW'(1), 1'b0, 1'b0, '0, '0, 1'b0, y);
    check_eq("post_rst_impulse", y, 1);

    // Randomized traffic against the model.
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(3) == 0) write_coef(AW'($urandom), CW'($urandom));
      if ($urandom_range(9) == 0) pulse_clear();
      repeat ($urandom_range(2)) @(negedge clk);
      feed(DW'($urandom), ($urandom_range(7) == 0), ($urandom_range(3) == 0),
           AW'($urandom), CW'($urandom), ($urandom_range(4) == 0), y);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global guard so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fir_mac_sched.md
Name: fir_mac_sched

Overview:
- Time-multiplexed FIR controller for the FAS filter path. It shares one signed 16x20 multiplier across TAPS taps.
- Holds the sample history in a circular buffer and the coefficient table, loadable at run time.
- Per accepted input sample, it steps the tap index, drives multiplier operands, accumulates products and emits one filter output.
- Sits between the input sample stream and the external multiplier/output register stage.

Parameters:
- TAPS, 32, number of filter taps (power of two, >=2)
- DW, 16, sample width (signed two's complement)
- CW, 20, coefficient width (signed two's complement)
- ACCW, 44, accumulator/output width; must be >= DW+CW+log2(TAPS)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- data_valid  in  1  input sample strobe
- data_in  in  DW  signed input sample
- ready  out  1  high when a sample can be accepted (state IDLE)
- clear_hist  in  1  zero sample history; honoured only in IDLE
- coef_we  in  1  coefficient write strobe
- coef_addr  in  log2(TAPS)  coefficient index k
- coef_data  in  CW  signed coefficient value
- cfg_err  out  1  one-cycle pulse: coef_we or clear_hist arrived while busy (ignored)
- mul_a  out  DW  multiplier operand: sample x[n-k]
- mul_b  out  CW  multiplier operand: coef[k]
- mul_en  out  1  operands valid (state MAC)
- mul_p  in  DW+CW  signed product from the external combinational multiplier, same cycle as operands
- out_valid  out  1  one-cycle result strobe
- out_data  out  ACCW  signed filter result; held until next result

Behaviour:
- Reset (clk edge with rst=1):
  - state=IDLE, history and coefficients all zero, wr_ptr=0, k=0, acc=0.
  - out_valid=0, out_data=0, cfg_err=0.
  - ready=1 in the first cycle after reset is released.
  - rst mid-MAC aborts the computation; no out_valid is produced.
- States: IDLE -> MAC -> DONE -> IDLE.
- IDLE:
  - ready=1, mul_en=0, mul_a=0, mul_b=0.
  - data_valid=1: write data_in to hist[wr_ptr], acc<=0, k<=0, go to MAC.
- MAC:
  - Lasts exactly TAPS cycles, k=0..TAPS-1.
  - mul_a=hist[(wr_ptr-k) mod TAPS], mul_b=coef[k], mul_en=1.
  - Each cycle: acc <= acc + sign_extend(mul_p).
  - At k=TAPS-1, go to DONE.
- DONE (one cycle):
  - out_data<=final acc, out_valid=1.
  - wr_ptr<=wr_ptr+1, wrapping TAPS-1 -> 0. Go to IDLE.
- Latency: sample accepted at edge 0; out_valid high in cycle TAPS+1. Throughput is one sample per TAPS+2 cycles.
- Handshake:
  - data_valid is ignored while ready=0.
  - The upstream producer must hold its sample until ready=1.
- Arithmetic:
  - Products are sign-extended to ACCW. No rounding, truncation or saturation.
  - Unwritten history slots read as zero, so the first TAPS-1 outputs see zero history.
- Coefficient load:
  - coef_we in IDLE writes coef[coef_addr].
  - coef_we coincident with an accepted data_valid is applied at that edge; the following MAC uses the new value.
  - coef_we in MAC/DONE is dropped and cfg_err pulses the next cycle.
- clear_hist:
  - In IDLE it zeroes all history and resets wr_ptr=0.
  - If coincident with data_valid, the clear applies first; the new sample goes to hist[0] and all other slots are zero.
  - In MAC/DONE it is dropped and cfg_err pulses.
- Simultaneous dropped coef_we and clear_hist produce a single cfg_err pulse.

Decomposition:
- Shared package fas_pkg: state enum {IDLE, MAC, DONE}, default DW/CW/TAPS constants, and a sign-extend-to-ACCW function.
- One natural sub-module, fir_hist_ram: TAPS x DW register array with a write port, synchronous clear and combinational read by index. Coefficient table stays inline.

Test Plan (TAPS=4, tie mul_p to an ideal signed multiplier):
- Impulse: coef={1,2,3,4}; feed 1,0,0,0,0 -> out_data 1,2,3,4,0; out_valid exactly 6 cycles after each accept; ready low for 5 cycles after each accept.
- Sign extremes: coef[0]=20'hFFFFF (-1), others 0; feed -32768 -> out_data=+32768; then feed 32767 -> -32767.
- Wrap-around: coef all 1; feed 1..9 -> out_data 1,3,6,10,14,18,22,26,30 (wr_ptr wraps without glitch).
- Busy protection: during MAC, pulse data_valid, coef_we(addr0,99) and clear_hist -> all ignored, cfg_err single pulse, output unchanged versus reference model.
- Coincident config: in IDLE, assert data_valid=5 with coef_we(addr0,7) and clear_hist -> out_data=35, history else zero.
- Reset mid-MAC: assert rst at MAC cycle 2 -> no out_valid, out_data=0, ready=1 after release, next impulse behaves as after power-up.
